// File: rtl/csrss_watch.sv
// Per-thread shadow copy of one CSR, snooped from the CSR-store broadcast bus.
// Optional per-thread change pulse built only when CSRSS_WATCH_CHG_EN is defined.
module csrss_watch #(
    parameter logic [15:0] ADDR      = 16'h0000,
    parameter logic [63:0] RESET_VAL = 64'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  csrss_addr,
    input  logic [63:0]  csrss_data,
    input  logic         csrss_en,
    output logic [127:0] out_data,
    output logic [1:0]   chg
);

    logic [63:0] reg_t [2];
    logic        hit;
    logic        thr;

    // Bit 15 selects the thread and never takes part in the match.
    assign hit = csrss_en && (csrss_addr[14:0] == ADDR[14:0]);
    assign thr = csrss_addr[15];

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_t[0] <= RESET_VAL;
            reg_t[1] <= RESET_VAL;
        end else if (hit) begin
            reg_t[thr] <= csrss_data;
        end
    end

    assign out_data = {reg_t[1], reg_t[0]};

`ifdef CSRSS_WATCH_CHG_EN
    logic [1:0] chg_q;
    logic [1:0] chg_d;

    always_comb begin
        chg_d = '0;
        for (int unsigned t = 0; t < 2; t++) begin
            chg_d[t] = hit && (thr == t[0]) && (csrss_data != reg_t[t]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) chg_q <= '0;
        else     chg_q <= chg_d;
    end

    assign chg = chg_q;
`else
    assign chg = '0;
`endif

endmodule

// File: tb/tb_csrss_watch.sv
// Directed vector table plus randomized run against a behavioural model of csrss_watch.
module tb_csrss_watch;

    localparam logic [15:0] ADDR = 16'h0341;
    localparam logic [63:0] RV   = 64'h0;
`ifdef CSRSS_WATCH_CHG_EN
    localparam bit CHG_ON = 1'b1;
`else
    localparam bit CHG_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  csrss_addr;
    logic [63:0]  csrss_data;
    logic         csrss_en;
    logic [127:0] out_data;
    logic [1:0]   chg;

    int errors = 0;
    int checks = 0;

    csrss_watch #(.ADDR(ADDR), .RESET_VAL(RV)) dut (
        .clk        (clk),
        .rst        (rst),
        .csrss_addr (csrss_addr),
        .csrss_data (csrss_data),
        .csrss_en   (csrss_en),
        .out_data   (out_data),
        .chg        (chg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] addr;
        logic [63:0] data;
        logic [63:0] exp_lo;
        logic [63:0] exp_hi;
        logic [1:0]  exp_chg;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [127:0] exp_d, input logic [1:0] exp_c);
        checks++;
        if (out_data !== exp_d) begin
            errors++;
            $display("FAIL %s: out_data=%h expected %h", name, out_data, exp_d);
        end
        checks++;
        if (chg !== exp_c) begin
            errors++;
            $display("FAIL %s chg: chg=%b expected %b", name, chg, exp_c);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [15:0] a, input logic [63:0] d);
        @(negedge clk);
        rst = r; csrss_en = e; csrss_addr = a; csrss_data = d;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a two-entry array of held values.
    logic [63:0] m [2];
    logic [1:0]  m_chg;

    task automatic model_step(input logic r, input logic e, input logic [15:0] a, input logic [63:0] d);
        m_chg = 2'b00;
        if (r) begin
            m[0] = RV; m[1] = RV;
        end else if (e && a[14:0] == ADDR[14:0]) begin
            if (CHG_ON && m[a[15]] != d) m_chg[a[15]] = 1'b1;
            m[a[15]] = d;
        end
    endtask

    initial begin
        rst = 1'b1; csrss_en = 1'b0; csrss_addr = '0; csrss_data = '0;

        vecs[0]  = '{1'b1, 1'b0, 16'h0341, 64'h0,         64'h0,    64'h0,         2'b00};
        vecs[1]  = '{1'b0, 1'b1, 16'h0341, 64'h1234,      64'h1234, 64'h0,         2'b01};
        vecs[2]  = '{1'b0, 1'b1, 16'h8341, 64'hDEAD_BEEF, 64'h1234, 64'hDEAD_BEEF, 2'b10};
        vecs[3]  = '{1'b0, 1'b1, 16'h0342, 64'hAAAA,      64'h1234, 64'hDEAD_BEEF, 2'b00};
        vecs[4]  = '{1'b0, 1'b0, 16'h0341, 64'hBBBB,      64'h1234, 64'hDEAD_BEEF, 2'b00};
        vecs[5]  = '{1'b0, 1'b1, 16'h4341, 64'hCCCC,      64'h1234, 64'hDEAD_BEEF, 2'b00};
        vecs[6]  = '{1'b0, 1'b1, 16'h0341, 64'h1234,      64'h1234, 64'hDEAD_BEEF, 2'b00};
        vecs[7]  = '{1'b0, 1'b1, 16'h0341, 64'h1235,      64'h1235, 64'hDEAD_BEEF, 2'b01};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 64'h0,         64'h1235, 64'hDEAD_BEEF, 2'b00};
        vecs[9]  = '{1'b1, 1'b1, 16'h0341, 64'h5555,      64'h0,    64'h0,         2'b00};
        vecs[10] = '{1'b0, 1'b1, 16'h8341, 64'h0,         64'h0,    64'h0,         2'b00};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d", i), {vecs[i].exp_hi, vecs[i].exp_lo},
                  CHG_ON ? vecs[i].exp_chg : 2'b00);
        end

        // Hand sequence: change pulse lasts exactly one cycle, value held while idle.
        drive(1'b0, 1'b1, 16'h8341, 64'h77);
        check("seq_wr", {64'h77, 64'h0}, CHG_ON ? 2'b10 : 2'b00);
        drive(1'b0, 1'b0, 16'h8341, 64'h99);
        check("seq_hold1", {64'h77, 64'h0}, 2'b00);
        drive(1'b0, 1'b0, 16'h8341, 64'h99);
        check("seq_hold2", {64'h77, 64'h0}, 2'b00);

        // Randomized run against the model.
        m[0] = 64'h0; m[1] = 64'h77;
        for (int i = 0; i < 400; i++) begin
            logic        r, e;
            logic [15:0] a;
            logic [63:0] d;
            r = ($urandom_range(0, 29) == 0);
            e = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 2) != 0) ? {1'($urandom), ADDR[14:0]} : 16'($urandom);
            d = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) d = m[a[15]];
            drive(r, e, a, d);
            model_step(r, e, a, d);
            check($sformatf("rnd%0d", i), {m[1], m[0]}, m_chg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
